msrv32_lsu_bus_ctrl: RTL and testbench

Load/store bus controller for the msrv32 core, sitting directly downstream of the decode/execute pipeline register. It consumes the registered load size, load-unsigned flag and ALU-computed effective address, and runs a request/acknowledge transaction on the data-memory bus. For loads, it aligns and extends the returned data for the write-back mux; for stores, it generates byte-lane write data and a byte mask. While a transaction is outstanding it stalls the pipeline.

---
 rtl/msrv32_lsu_bus_ctrl_if.sv | 38 +++
 rtl/msrv32_lsu_bus_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_msrv32_lsu_bus_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/msrv32_lsu_bus_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the msrv32 load/store bus controller.
// slave = controller view, master = execute stage plus data memory (bench) view.
interface msrv32_lsu_bus_ctrl_if;
  logic        ld_req_in;
  logic        st_req_in;
  logic [31:0] addr_in;
  logic [31:0] st_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [31:0] dm_rdata_in;
  logic        dm_ack_in;
  logic [31:0] dm_addr_out;
  logic [31:0] dm_wdata_out;
  logic [3:0]  dm_wmask_out;
  logic        dm_rd_req_out;
  logic        dm_wr_req_out;
  logic [31:0] load_data_out;
  logic        lsu_done_out;
  logic        lsu_stall_out;
  logic        bus_err_out;
  logic        misaligned_out;

  // Handshake: a request (dm_rd_req_out/dm_wr_req_out) is held until the single
  // cycle in which dm_ack_in is sampled high, or until the wait budget expires.
  modport slave (
    input  ld_req_in, st_req_in, addr_in, st_data_in, load_size_in, load_unsigned_in,
    input  dm_rdata_in, dm_ack_in,
    output dm_addr_out, dm_wdata_out, dm_wmask_out, dm_rd_req_out, dm_wr_req_out,
    output load_data_out, lsu_done_out, lsu_stall_out, bus_err_out, misaligned_out
  );

  modport master (
    output ld_req_in, st_req_in, addr_in, st_data_in, load_size_in, load_unsigned_in,
    output dm_rdata_in, dm_ack_in,
    input  dm_addr_out, dm_wdata_out, dm_wmask_out, dm_rd_req_out, dm_wr_req_out,
    input  load_data_out, lsu_done_out, lsu_stall_out, bus_err_out, misaligned_out
  );
endinterface

// File: rtl/msrv32_lsu_bus_ctrl.sv
// msrv32 load/store bus controller: request/ack data-memory transactions, load alignment, store lanes.
// Optional alignment checking is enabled by defining MSRV32_LSU_MISALIGN_CHECK_EN.
module msrv32_lsu_bus_ctrl #(
  parameter int unsigned DBUS_WAIT_MAX = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  msrv32_lsu_bus_ctrl_if.slave   bus,
  output logic [1:0]             dbg_state_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(DBUS_WAIT_MAX - 1);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_is_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_dm_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_rd_req;
  logic        r_wr_req;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_bus_err;

  logic        w_req;
  logic        w_accept;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_req = bus.ld_req_in | bus.st_req_in;

`ifdef MSRV32_LSU_MISALIGN_CHECK_EN
  logic w_misaligned;
  logic r_misaligned;
  assign w_misaligned = ((bus.load_size_in == 2'b01) && bus.addr_in[0]) ||
                        (bus.load_size_in[1] && (bus.addr_in[1:0] != 2'b00));
  assign w_accept           = w_req & ~w_misaligned;
  assign bus.misaligned_out = r_misaligned;
`else
  assign w_accept           = w_req;
  assign bus.misaligned_out = 1'b0;
`endif

  // Store lane generation from the live request; size 11 behaves as word.
  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = bus.st_data_in;
    case (bus.load_size_in)
      2'b00: begin
        w_mask  = 4'b0001 << bus.addr_in[1:0];
        w_wdata = {4{bus.st_data_in[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011 << {bus.addr_in[1], 1'b0};
        w_wdata = {2{bus.st_data_in[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = bus.st_data_in;
      end
    endcase
  end

  // Load alignment uses the attributes registered when the request was accepted.
  always_comb begin
    w_byte      = 8'h00;
    w_half      = r_addr_lo[1] ? bus.dm_rdata_in[31:16] : bus.dm_rdata_in[15:0];
    w_load_data = bus.dm_rdata_in;
    case (r_addr_lo)
      2'b00:   w_byte = bus.dm_rdata_in[7:0];
      2'b01:   w_byte = bus.dm_rdata_in[15:8];
      2'b10:   w_byte = bus.dm_rdata_in[23:16];
      default: w_byte = bus.dm_rdata_in[31:24];
    endcase
    case (r_size)
      2'b00:   w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = bus.dm_rdata_in;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 8'd0;
      r_is_store  <= 1'b0;
      r_size      <= 2'b00;
      r_unsigned  <= 1'b0;
      r_addr_lo   <= 2'b00;
      r_dm_addr   <= 32'h0;
      r_wdata     <= 32'h0;
      r_wmask     <= 4'h0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_load_data <= 32'h0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
`ifdef MSRV32_LSU_MISALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_bus_err <= 1'b0;
`ifdef MSRV32_LSU_MISALIGN_CHECK_EN
      r_misaligned <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state    <= S_BUSY;
            r_wait_cnt <= 8'd0;
            r_dm_addr  <= {bus.addr_in[31:2], 2'b00};
            r_is_store <= bus.st_req_in;
            r_size     <= bus.load_size_in;
            r_unsigned <= bus.load_unsigned_in;
            r_addr_lo  <= bus.addr_in[1:0];
            // Store wins when both requests are raised together.
            if (bus.st_req_in) begin
              r_wr_req <= 1'b1;
              r_wmask  <= w_mask;
              r_wdata  <= w_wdata;
            end else begin
              r_rd_req <= 1'b1;
              r_wmask  <= 4'h0;
              r_wdata  <= 32'h0;
            end
          end
`ifdef MSRV32_LSU_MISALIGN_CHECK_EN
          else if (w_req) begin
            r_misaligned <= 1'b1;
          end
`endif
        end
        S_BUSY: begin
          if (bus.dm_ack_in) begin
            r_state  <= S_DONE;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_done   <= 1'b1;
            if (!r_is_store) r_load_data <= w_load_data;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state   <= S_IDLE;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
            r_bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.dm_addr_out   = r_dm_addr;
  assign bus.dm_wdata_out  = r_wdata;
  assign bus.dm_wmask_out  = r_wmask;
  assign bus.dm_rd_req_out = r_rd_req;
  assign bus.dm_wr_req_out = r_wr_req;
  assign bus.load_data_out = r_load_data;
  assign bus.lsu_done_out  = r_done;
  assign bus.bus_err_out   = r_bus_err;
  assign bus.lsu_stall_out = ((r_state == S_IDLE) && w_accept) || (r_state == S_BUSY);
  assign dbg_state_out     = r_state;

endmodule

// File: tb/tb_msrv32_lsu_bus_ctrl.sv
// Directed bench for msrv32_lsu_bus_ctrl: driver tasks push expected completion events,
// a negedge monitor pops and compares them against done/error/misaligned pulses.
module tb_msrv32_lsu_bus_ctrl;
  localparam int DW = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  msrv32_lsu_bus_ctrl_if bus_if();

  msrv32_lsu_bus_ctrl #(.DBUS_WAIT_MAX(DW)) dut (
    .clk_in        (clk),
    .reset_n_in    (rst_n),
    .bus           (bus_if),
    .dbg_state_out (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [34:0] exp_q[$];      // {done, err, misaligned, load_data}
  logic [31:0] last_ld = 32'h0;
  logic [34:0] mon_act;
  logic [34:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (bus_if.lsu_done_out || bus_if.bus_err_out || bus_if.misaligned_out)) begin
      mon_act = {bus_if.lsu_done_out, bus_if.bus_err_out, bus_if.misaligned_out, bus_if.load_data_out};
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL monitor_unexpected: got 0x%09h expected no event", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act === mon_exp) n_pass++;
        else $display("FAIL monitor_event: got 0x%09h expected 0x%09h", mon_act, mon_exp);
      end
    end
  end

  // One full transaction; ack_en=0 lets the wait budget expire.
  task automatic txn(input logic st, input logic ld, input logic [31:0] addr,
                     input logic [31:0] sdata, input logic [1:0] size, input logic uns,
                     input int waits, input logic ack_en, input logic [31:0] rdata,
                     input logic [31:0] exp_ld, input logic [3:0] exp_mask,
                     input logic [31:0] exp_wdata);
    int nw;
    @(posedge clk); #1;
    bus_if.st_req_in        = st;
    bus_if.ld_req_in        = ld;
    bus_if.addr_in          = addr;
    bus_if.st_data_in       = sdata;
    bus_if.load_size_in     = size;
    bus_if.load_unsigned_in = uns;
    if (!ack_en) exp_q.push_back({3'b010, last_ld});
    else if (st) exp_q.push_back({3'b100, last_ld});
    else begin
      exp_q.push_back({3'b100, exp_ld});
      last_ld = exp_ld;
    end
    @(negedge clk);
    check("stall_on_req", {31'b0, bus_if.lsu_stall_out}, 32'd1);
    @(posedge clk); #1;
    bus_if.st_req_in = 1'b0;
    bus_if.ld_req_in = 1'b0;
    nw = ack_en ? waits : DW - 1;
    for (int k = 0; k <= nw; k++) begin
      if (ack_en && k == nw) begin
        bus_if.dm_ack_in   = 1'b1;
        bus_if.dm_rdata_in = rdata;
      end
      @(negedge clk);
      if (k == 0) begin
        check("dm_addr", bus_if.dm_addr_out, {addr[31:2], 2'b00});
        check("rd_req", {31'b0, bus_if.dm_rd_req_out}, {31'b0, ~st});
        check("wr_req", {31'b0, bus_if.dm_wr_req_out}, {31'b0, st});
        if (st) begin
          check("wmask", {28'b0, bus_if.dm_wmask_out}, {28'b0, exp_mask});
          check("wdata", bus_if.dm_wdata_out, exp_wdata);
        end
      end
      check("stall_busy", {31'b0, bus_if.lsu_stall_out}, 32'd1);
      @(posedge clk); #1;
      bus_if.dm_ack_in = 1'b0;
    end
    @(negedge clk);
    check("done_latency", {31'b0, bus_if.lsu_done_out}, {31'b0, ack_en});
    check("bus_err", {31'b0, bus_if.bus_err_out}, {31'b0, ~ack_en});
    check("req_released", {30'b0, bus_if.dm_rd_req_out, bus_if.dm_wr_req_out}, 32'd0);
    check("stall_released", {31'b0, bus_if.lsu_stall_out}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_if.ld_req_in = 1'b0;
    bus_if.st_req_in = 1'b0;
    bus_if.addr_in = 32'h0;
    bus_if.st_data_in = 32'h0;
    bus_if.load_size_in = 2'b00;
    bus_if.load_unsigned_in = 1'b0;
    bus_if.dm_rdata_in = 32'h0;
    bus_if.dm_ack_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outputs", {bus_if.dm_addr_out[3:0], bus_if.dm_wmask_out, bus_if.dm_rd_req_out,
                          bus_if.dm_wr_req_out, bus_if.lsu_done_out, bus_if.lsu_stall_out,
                          bus_if.bus_err_out, bus_if.misaligned_out, 18'b0, dbg_state}, 32'd0);
    check("rst_wide", bus_if.dm_addr_out | bus_if.dm_wdata_out | bus_if.load_data_out, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {29'b0, bus_if.dm_rd_req_out, bus_if.dm_wr_req_out, bus_if.lsu_stall_out}, 32'd0);

    // Signed byte load, ack on first BUSY cycle
    txn(1'b0, 1'b1, 32'h103, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 4'h0, 32'h0);
    // Unsigned half load, two wait cycles
    txn(1'b0, 1'b1, 32'h202, 32'h0, 2'b01, 1'b1, 2, 1'b1, 32'h8001_FFFF, 32'h0000_8001, 4'h0, 32'h0);
    // Store byte with simultaneous load request
    txn(1'b1, 1'b1, 32'h301, 32'h0000_00AB, 2'b00, 1'b0, 0, 1'b1, 32'h0, 32'h0, 4'b0010, 32'hABAB_ABAB);
    txn(1'b1, 1'b0, 32'h302, 32'h1234_5678, 2'b01, 1'b0, 1, 1'b1, 32'h0, 32'h0, 4'b1100, 32'h5678_5678);
    txn(1'b1, 1'b0, 32'h400, 32'hDEAD_BEEF, 2'b10, 1'b0, 0, 1'b1, 32'h0, 32'h0, 4'b1111, 32'hDEAD_BEEF);
    txn(1'b0, 1'b1, 32'h200, 32'h0, 2'b01, 1'b0, 0, 1'b1, 32'h1234_8765, 32'hFFFF_8765, 4'h0, 32'h0);
    txn(1'b0, 1'b1, 32'h102, 32'h0, 2'b00, 1'b1, 1, 1'b1, 32'h80FF_1234, 32'h0000_00FF, 4'h0, 32'h0);
    txn(1'b0, 1'b1, 32'h404, 32'h0, 2'b11, 1'b0, 0, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'h0, 32'h0);
    // Timeout, then ack in the last permitted cycle
    txn(1'b0, 1'b1, 32'h600, 32'h0, 2'b10, 1'b0, 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    txn(1'b0, 1'b1, 32'h604, 32'h0, 2'b10, 1'b0, DW - 1, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'h0, 32'h0);

    // Misaligned word load
`ifdef MSRV32_LSU_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    bus_if.ld_req_in = 1'b1;
    bus_if.addr_in = 32'h2;
    bus_if.load_size_in = 2'b10;
    exp_q.push_back({3'b001, last_ld});
    @(negedge clk);
    check("misalign_no_stall", {31'b0, bus_if.lsu_stall_out}, 32'd0);
    @(posedge clk); #1;
    bus_if.ld_req_in = 1'b0;
    @(negedge clk);
    check("misalign_no_req", {30'b0, dbg_state}, 32'd0);
    check("misalign_rd_req", {31'b0, bus_if.dm_rd_req_out}, 32'd0);
`else
    txn(1'b0, 1'b1, 32'h2, 32'h0, 2'b10, 1'b0, 0, 1'b1, 32'h1122_3344, 32'h1122_3344, 4'h0, 32'h0);
`endif

    // Ack while IDLE is ignored
    @(posedge clk); #1;
    bus_if.dm_ack_in = 1'b1;
    @(posedge clk); #1;
    bus_if.dm_ack_in = 1'b0;
    @(negedge clk);
    check("idle_ack_ignored", {29'b0, bus_if.lsu_done_out, dbg_state}, 32'd0);

    // Asynchronous reset during BUSY
    @(posedge clk); #1;
    bus_if.ld_req_in = 1'b1;
    bus_if.addr_in = 32'h500;
    bus_if.load_size_in = 2'b10;
    @(posedge clk); #1;
    bus_if.ld_req_in = 1'b0;
    @(negedge clk);
    check("busy_before_rst", {31'b0, bus_if.dm_rd_req_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req_drop", {31'b0, bus_if.dm_rd_req_out}, 32'd0);
    check("async_rst_state", {30'b0, dbg_state}, 32'd0);
    check("async_rst_ld_data", bus_if.load_data_out, 32'd0);
    last_ld = 32'h0;
    @(negedge clk);
    check("rst_no_done", {30'b0, bus_if.lsu_done_out, bus_if.bus_err_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    txn(1'b0, 1'b1, 32'h701, 32'h0, 2'b00, 1'b0, 0, 1'b1, 32'h0000_7F00, 32'h0000_007F, 4'h0, 32'h0);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
